change_monitor: RTL and testbench
=================================

CHANGE_MONITOR -- requirements
Module: change_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each monitored channel.
REQ-002 SHALL have parameter CHANNELS, default 2: number of monitored channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 8: event FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TS_WIDTH, default 16: timestamp counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port ch_in, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port ch_en, input, CHANNELS: per-channel watch enable.
REQ-009 SHALL have port ev_ready, input, 1: consumer accepts the head event.
REQ-010 SHALL have port ovf_clr, input, 1: clears overflow status.
REQ-011 SHALL have port ev_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port ev_mask, output, CHANNELS: channels that changed in the head event.
REQ-013 SHALL have port ev_data, output, CHANNELS*WIDTH: channel snapshot taken at the head event.
REQ-014 SHALL have port ev_time, output, TS_WIDTH: timestamp of the head event.
REQ-015 SHALL have port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-016 SHALL have port drop_cnt, output, 8: number of dropped events, saturating at 255.
REQ-017 SHALL have port level, output, clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-018 SHALL run a free-running timestamp counter that increments every cycle and wraps from all-ones to 0.
REQ-019 SHALL register ch_in every cycle into a prev register.
REQ-020 SHALL define the change mask as diff[k] = (ch_in[k] != prev[k]) & ch_en[k]; an event exists when the mask is nonzero.
REQ-021 SHALL suppress event detection in the first cycle after reset release (prime state); the prev register still loads.
REQ-022 SHALL push each event as one record {current timestamp, diff, ch_in} in the same cycle the change is seen; the record is visible at the outputs on the next cycle (1-cycle latency from input change to ev_valid).
REQ-023 SHALL present the FIFO as first-word-fall-through: ev_valid = (level != 0), and ev_mask/ev_data/ev_time always show the head entry.
REQ-024 SHALL pop the head entry when ev_valid & ev_ready are both high at a clock edge; ev_ready while empty has no effect.
REQ-025 SHALL accept a simultaneous push and pop when full; level stays DEPTH and no drop occurs.
REQ-026 SHALL, on a push when full without a pop, discard the new record, set overflow, and increment drop_cnt (saturating at 255).
REQ-027 SHALL, on ovf_clr, clear overflow and drop_cnt next cycle; a drop in the same cycle takes priority, leaving overflow=1 and drop_cnt=1.
REQ-028 SHALL wrap FIFO read/write pointers modulo DEPTH, with no bubble at wrap-around.
REQ-029 SHALL ignore a change on a channel whose ch_en is 0, while prev still tracks that channel.
REQ-030 SHALL keep ev_data/ev_mask/ev_time unchanged while ev_valid is high and ev_ready is low.

Reset
REQ-031 SHALL, while rst_n=0, set immediately: timestamp=0, prev=0, level=0, pointers=0, ev_valid=0, overflow=0, drop_cnt=0, prime state active.
REQ-032 SHALL, when rst_n asserts mid-operation, discard all queued events at once; no partial record survives.
REQ-033 SHALL drive ev_mask, ev_data and ev_time to 0 while the FIFO is empty after reset.

Verification
REQ-034 Bench SHALL cover: CHANNELS=2, WIDTH=32; ch0 goes 0->5 at timestamp 10 -> next cycle ev_valid=1, ev_mask=2'b01, ev_time=10, ev_data[31:0]=5.
REQ-035 Bench SHALL cover: ch0 and ch1 change in the same cycle -> a single event with ev_mask=2'b11.
REQ-036 Bench SHALL cover: DEPTH=4, ev_ready=0, 6 consecutive changes -> level=4, overflow=1, drop_cnt=2; draining returns the first 4 events in order.
REQ-037 Bench SHALL cover: full FIFO with a change and ev_ready=1 in the same cycle -> level stays 4, drop_cnt unchanged.
REQ-038 Bench SHALL cover: ch_en=2'b10 with ch0 toggling -> no events; a ch1 change -> ev_mask=2'b10.
REQ-039 Bench SHALL cover: TS_WIDTH=4, a change near the wrap point -> ev_time values 15 then 0 in order; rst_n pulsed mid-stream -> ev_valid=0 immediately, and no event is produced in the first cycle after release.

Source files
------------

// File: rtl/change_monitor.sv
// Change monitor: watches channels for value changes and queues timestamped
// snapshots into a first-word-fall-through event FIFO with drop accounting.
module change_monitor #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*WIDTH-1:0]    ch_in,
   input  logic [CHANNELS-1:0]          ch_en,
   input  logic                         ev_ready,
   input  logic                         ovf_clr,
   output logic                         ev_valid,
   output logic [CHANNELS-1:0]          ev_mask,
   output logic [CHANNELS*WIDTH-1:0]    ev_data,
   output logic [TS_WIDTH-1:0]          ev_time,
   output logic                         overflow,
   output logic [7:0]                   drop_cnt,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = CHANNELS * WIDTH;
   localparam int RW = TS_WIDTH + CHANNELS + DW;
   localparam logic [AW:0]         FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0]         LVL_ONE  = 1;
   localparam logic [AW-1:0]       PTR_ONE  = 1;
   localparam logic [TS_WIDTH-1:0] TS_ONE   = 1;

   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [DW-1:0]       prev_q, prev_d;
   logic                prime_q, prime_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         level_q, level_d;
   logic                ovf_q, ovf_d;
   logic [7:0]          drop_q, drop_d;
   logic [RW-1:0]       mem_q [DEPTH];

   logic [CHANNELS-1:0] diff;
   logic [RW-1:0]       head;
   logic                push, pop, full, wr_en, drop;

   always_comb begin
      diff = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         diff[k] = ch_en[k] &&
                   (ch_in[k*WIDTH +: WIDTH] != prev_q[k*WIDTH +: WIDTH]);
      end
      push  = !prime_q && (diff != '0);
      pop   = ev_valid && ev_ready;
      full  = (level_q == FULL_LVL);
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;
   end

   always_comb begin
      ts_d     = ts_q + TS_ONE;
      prev_d   = ch_in;
      prime_d  = 1'b0;
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      level_d  = level_q;
      unique case ({wr_en, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      ovf_d  = ovf_q;
      drop_d = drop_q;
      // A drop in the same cycle as a clear restarts the count at one.
      if (drop) begin
         ovf_d = 1'b1;
         if (ovf_clr)
            drop_d = 8'd1;
         else if (drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
      end else if (ovf_clr) begin
         ovf_d  = 1'b0;
         drop_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q     <= '0;
         prev_q   <= '0;
         prime_q  <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         ts_q     <= ts_d;
         prev_q   <= prev_d;
         prime_q  <= prime_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is not reset; the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= {ts_q, diff, ch_in};
   end

   assign ev_valid = (level_q != '0);
   assign head     = ev_valid ? mem_q[rd_ptr_q] : '0;
   assign {ev_time, ev_mask, ev_data} = head;
   assign overflow = ovf_q;
   assign drop_cnt = drop_q;
   assign level    = level_q;

endmodule

// File: tb/tb_change_monitor.sv
// Bench for change_monitor: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_change_monitor;

   localparam int W  = 32;
   localparam int C  = 2;
   localparam int D  = 4;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [C*W-1:0]  ch_in = '0;
   logic [C-1:0]    ch_en = '0;
   logic            ev_ready = 1'b0;
   logic            ovf_clr = 1'b0;
   logic            ev_valid;
   logic [C-1:0]    ev_mask;
   logic [C*W-1:0]  ev_data;
   logic [TW-1:0]   ev_time;
   logic            overflow;
   logic [7:0]      drop_cnt;
   logic [$clog2(D):0] level;

   change_monitor #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .TS_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .ch_en(ch_en),
      .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid),
      .ev_mask(ev_mask), .ev_data(ev_data), .ev_time(ev_time),
      .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          t;
      logic [1:0]  m;
      logic [63:0] d;
   } rec_t;

   typedef struct {
      logic [31:0] c0;
      logic [31:0] c1;
      logic        rdy;
      logic        ev;
      logic [1:0]  mk;
      int          tm;
      logic [31:0] d0;
      int          lvl;
   } vec_t;

   rec_t        q[$];
   logic [63:0] m_prev;
   bit          m_prime;
   int          m_ts;
   bit          m_ovf;
   int          m_drop;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] cur0 = 0;
   logic [31:0] cur1 = 0;
   vec_t        tbl[14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_prev  = '0;
      m_prime = 1'b1;
      m_ts    = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;
   endtask

   task automatic model_step(input logic [63:0] ch, input logic [1:0] en,
                             input logic rdy, input logic clr);
      logic [1:0] diff;
      bit ev, pop, full, drop;
      rec_t r;
      diff[0] = en[0] && (ch[31:0] != m_prev[31:0]);
      diff[1] = en[1] && (ch[63:32] != m_prev[63:32]);
      ev   = !m_prime && (diff != 2'b00);
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == D);
      drop = ev && full && !pop;
      if (pop) void'(q.pop_front());
      if (ev && !drop) begin
         r.t = m_ts; r.m = diff; r.d = ch;
         q.push_back(r);
      end
      if (drop) begin
         m_ovf = 1'b1;
         m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
      end else if (clr) begin
         m_ovf = 1'b0;
         m_drop = 0;
      end
      m_prev  = ch;
      m_prime = 1'b0;
      m_ts    = (m_ts + 1) % 16;
   endtask

   task automatic check_model(input string tag);
      bit v;
      v = (q.size() != 0);
      chk({tag, ".valid"}, 64'(ev_valid), 64'(v));
      chk({tag, ".level"}, 64'(level), 64'(q.size()));
      chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
      chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
      chk({tag, ".mask"}, 64'(ev_mask), v ? 64'(q[0].m) : 64'd0);
      chk({tag, ".time"}, 64'(ev_time), v ? 64'(q[0].t) : 64'd0);
      chk({tag, ".data"}, ev_data, v ? q[0].d : 64'd0);
   endtask

   task automatic step(input logic [31:0] c0, input logic [31:0] c1,
                       input logic [1:0] en, input logic rdy,
                       input logic clr);
      ch_in    = {c1, c0};
      ch_en    = en;
      ev_ready = rdy;
      ovf_clr  = clr;
      cur0     = c0;
      cur1     = c1;
      model_step({c1, c0}, en, rdy, clr);
      @(posedge clk);
      @(negedge clk);
      check_model("model");
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst.valid_now", 64'(ev_valid), 64'd0);
      chk("rst.level_now", 64'(level), 64'd0);
      model_reset();
      check_model("rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_model("rel");
   endtask

   function automatic vec_t mkv(input logic [31:0] c0, input logic [31:0] c1,
                                input logic rdy, input logic ev,
                                input logic [1:0] mk, input int tm,
                                input logic [31:0] d0, input int lvl);
      vec_t v;
      v.c0 = c0; v.c1 = c1; v.rdy = rdy; v.ev = ev;
      v.mk = mk; v.tm = tm; v.d0 = d0; v.lvl = lvl;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 10; i++)
         tbl[i] = mkv(0, 0, 1'b0, 1'b0, 2'b00, 0, 0, 0);
      tbl[10] = mkv(5, 0, 1'b0, 1'b1, 2'b01, 10, 5, 1);
      tbl[11] = mkv(5, 7, 1'b1, 1'b1, 2'b10, 11, 5, 1);
      tbl[12] = mkv(6, 8, 1'b1, 1'b1, 2'b11, 12, 6, 1);
      tbl[13] = mkv(6, 8, 1'b1, 1'b0, 2'b00, 0, 0, 0);

      model_reset();
      #1;
      chk("reset.valid", 64'(ev_valid), 64'd0);
      chk("reset.level", 64'(level), 64'd0);
      chk("reset.ovf", 64'(overflow), 64'd0);
      chk("reset.drop", 64'(drop_cnt), 64'd0);
      chk("reset.mask", 64'(ev_mask), 64'd0);
      chk("reset.time", 64'(ev_time), 64'd0);
      chk("reset.data", ev_data, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].c0, tbl[i].c1, 2'b11, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d.valid", i), 64'(ev_valid), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d.mask", i), 64'(ev_mask), 64'(tbl[i].mk));
         chk($sformatf("tbl%0d.time", i), 64'(ev_time), 64'(tbl[i].tm));
         chk($sformatf("tbl%0d.d0", i), 64'(ev_data[31:0]), 64'(tbl[i].d0));
         chk($sformatf("tbl%0d.level", i), 64'(level), 64'(tbl[i].lvl));
      end

      for (int i = 0; i < 4; i++) begin
         step(cur0 ^ 32'd1, cur1, 2'b10, 1'b0, 1'b0);
         chk("en_mask.no_event", 64'(ev_valid), 64'd0);
      end
      step(cur0, cur1 + 1, 2'b10, 1'b0, 1'b0);
      chk("en_mask.ch1_valid", 64'(ev_valid), 64'd1);
      chk("en_mask.ch1_mask", 64'(ev_mask), 64'd2);
      step(cur0, cur1, 2'b11, 1'b1, 1'b0);

      for (int i = 0; i < 6; i++)
         step(1001 + i, cur1, 2'b11, 1'b0, 1'b0);
      chk("ovf.level", 64'(level), 64'd4);
      chk("ovf.flag", 64'(overflow), 64'd1);
      chk("ovf.drop", 64'(drop_cnt), 64'd2);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("drain%0d.d0", j), 64'(ev_data[31:0]), 64'(1001 + j));
         step(cur0, cur1, 2'b11, 1'b1, 1'b0);
      end
      chk("drain.empty", 64'(ev_valid), 64'd0);
      step(cur0, cur1, 2'b11, 1'b0, 1'b1);
      chk("clr.ovf", 64'(overflow), 64'd0);
      chk("clr.drop", 64'(drop_cnt), 64'd0);

      for (int i = 0; i < 4; i++)
         step(2001 + i, cur1, 2'b11, 1'b0, 1'b0);
      step(2005, cur1, 2'b11, 1'b1, 1'b0);
      chk("full_pp.level", 64'(level), 64'd4);
      chk("full_pp.drop", 64'(drop_cnt), 64'd0);
      chk("full_pp.ovf", 64'(overflow), 64'd0);
      chk("full_pp.head", 64'(ev_data[31:0]), 64'd2002);
      step(2006, cur1, 2'b11, 1'b0, 1'b1);
      chk("drop_clr.ovf", 64'(overflow), 64'd1);
      chk("drop_clr.drop", 64'(drop_cnt), 64'd1);
      step(2007, cur1, 2'b11, 1'b0, 1'b0);
      chk("drop2.drop", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 4; i++)
         step(cur0, cur1, 2'b11, 1'b1, 1'b0);

      for (int i = 0; i < 16 && m_ts != 15; i++)
         step(cur0, cur1, 2'b11, 1'b1, 1'b0);
      step(cur0 + 1, cur1, 2'b11, 1'b0, 1'b0);
      step(cur0 + 1, cur1, 2'b11, 1'b0, 1'b0);
      chk("wrap.level", 64'(level), 64'd2);
      chk("wrap.t15", 64'(ev_time), 64'd15);
      step(cur0, cur1 + 1, 2'b11, 1'b1, 1'b0);
      chk("wrap.t0", 64'(ev_time), 64'd0);
      chk("wrap.level2", 64'(level), 64'd2);

      mid_reset();
      step(77, 0, 2'b11, 1'b0, 1'b0);
      chk("prime.no_event", 64'(ev_valid), 64'd0);
      step(77, 0, 2'b11, 1'b0, 1'b0);
      chk("prime.idle", 64'(ev_valid), 64'd0);
      step(78, 0, 2'b11, 1'b0, 1'b0);
      chk("prime.after_valid", 64'(ev_valid), 64'd1);
      chk("prime.after_time", 64'(ev_time), 64'd2);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            mid_reset();
         end else begin
            step($urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
